param_down_timer: RTL

Parameterised, loadable down-counter with a clock prescaler, terminal-count pulse and optional auto-reload. It succeeds the fixed 4-bit free-running decrementer. It is the timing source for traffic-light phase durations: the controller FSM loads a phase length, waits for tc, then advances state. In auto-reload mode it also serves as a periodic tick generator.

---
 rtl/param_down_timer.sv | 45 ++++
 1 files changed

// File: rtl/param_down_timer.sv
// param_down_timer: loadable prescaled down-counter with terminal-count pulse and optional auto-reload
module param_down_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    logic [WIDTH-1:0] reload;
    logic [PW-1:0] pre;
    logic run, step, last;
    assign run  = busy && enable;
    assign step = run && pre == PMAX;
    assign last = count == WIDTH'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            reload <= '0;
            pre    <= '0;
            tc     <= 1'b0;
            busy   <= 1'b0;
        end else if (load) begin
            count  <= load_value;
            reload <= load_value;
            pre    <= '0;
            tc     <= 1'b0;
            busy   <= load_value != '0;
        end else begin
            tc <= step && last;
            if (run) pre <= step ? '0 : pre + 1'b1;
            if (step) count <= last ? (auto_reload ? reload : '0) : count - 1'b1;
            // expiry without reload ends the countdown
            if (step && last && !auto_reload) busy <= 1'b0;
        end
    end
endmodule
